mux4_scan_ctrl: RTL and testbench

- Sequencer that sits directly upstream of the 4->1 multiplexer. It drives the mux `sel` and reads back the mux output `z`.
- Walks the enabled channels in round-robin order, waits a configurable settle time on each channel, then captures `z` into a per-channel result register.
- Provides a start/busy/done handshake to the controlling logic, plus an abort input.

---
 rtl/mux4_scan_pkg.sv | 40 ++++
 rtl/mux4_scan_dwell.sv | 28 ++
 rtl/mux4_scan_ctrl.sv | 115 +++++++++++
 tb/tb_mux4_scan_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mux4_scan_pkg.sv
// Shared types and channel-walk helpers for the 4->1 mux scan sequencer.
package mux4_scan_pkg;

  localparam int NCH = 4;

  typedef enum logic [1:0] {IDLE, SETTLE, FINISH} scan_state_t;

  typedef logic [NCH-1:0] ch_mask_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } ch_pick_t;

  // Lowest enabled channel strictly above cur; descending loop lets the lowest win.
  function automatic ch_pick_t next_ch(input ch_mask_t mask, input logic [1:0] cur);
    ch_pick_t r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        r.found = 1'b1;
        r.idx   = 2'(i);
      end
    end
    return r;
  endfunction

  function automatic ch_pick_t first_ch(input ch_mask_t mask);
    ch_pick_t r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        r.found = 1'b1;
        r.idx   = 2'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux4_scan_dwell.sv
// Dwell down-counter: load to DWELL-1, decrement toward zero, flag zero.
module mux4_scan_dwell #(
  parameter int DWELL = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = $clog2(DWELL + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(DWELL - 1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Round-robin scan sequencer driving a 4->1 mux select and capturing z per channel.
// Optional MUX4_SCAN_CHANGE_EN adds a per-channel change mask between completed scans.
module mux4_scan_ctrl
  import mux4_scan_pkg::*;
#(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] ch_en,
  input  logic       z_in,
  output logic [1:0] sel,
  output logic       busy,
  output logic       done,
  output logic [3:0] sample
`ifdef MUX4_SCAN_CHANGE_EN
  ,
  output logic [3:0] changed
`endif
);

  // Handshake: start is honoured only in IDLE; busy is high for the whole
  // scan; done pulses for one cycle at completion; abort ends a scan silently.
  scan_state_t state, state_nxt;
  ch_mask_t    mask_q, mask_nxt;
  logic [1:0]  sel_nxt;
  logic        cnt_load, cnt_dec, cnt_zero, capture;
  ch_pick_t    first_pick, next_pick;

  mux4_scan_dwell #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  assign first_pick = first_ch(ch_en);
  assign next_pick  = next_ch(mask_q, sel);

  always_comb begin
    state_nxt = state;
    mask_nxt  = mask_q;
    sel_nxt   = sel;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (first_pick.found) begin
            mask_nxt  = ch_en;
            sel_nxt   = first_pick.idx;
            cnt_load  = 1'b1;
            state_nxt = SETTLE;
          end else begin
            state_nxt = FINISH;
          end
        end
      end
      SETTLE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          capture = 1'b1;
          if (next_pick.found) begin
            sel_nxt  = next_pick.idx;
            cnt_load = 1'b1;
          end else begin
            state_nxt = FINISH;
          end
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mask_q <= '0;
      sel    <= '0;
      sample <= '0;
    end else begin
      state  <= state_nxt;
      mask_q <= mask_nxt;
      sel    <= sel_nxt;
      if (capture) sample[sel] <= z_in;
    end
  end

  assign busy = (state == SETTLE);
  assign done = (state == FINISH);

`ifdef MUX4_SCAN_CHANGE_EN
  logic [3:0] snap;

  // Compared on the FINISH cycle, when sample already holds the last capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap    <= '0;
      changed <= '0;
    end else if (state == FINISH) begin
      changed <= sample ^ snap;
      snap    <= sample;
    end
  end
`endif

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Randomized bench for mux4_scan_ctrl against a scan-level reference model.
// Define MUX4_SCAN_CHANGE_EN on both RTL and bench to cover the change mask.
module tb_mux4_scan_ctrl;

  localparam int DWELL = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] ch_en = 4'h0;
  logic [3:0] d = 4'h0;
  logic       z_in;
  logic [1:0] sel;
  logic       busy;
  logic       done;
  logic [3:0] sample;
`ifdef MUX4_SCAN_CHANGE_EN
  logic [3:0] changed;
`endif

  mux4_scan_ctrl #(.DWELL(DWELL)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .ch_en  (ch_en),
    .z_in   (z_in),
    .sel    (sel),
    .busy   (busy),
    .done   (done),
    .sample (sample)
`ifdef MUX4_SCAN_CHANGE_EN
    ,
    .changed(changed)
`endif
  );

  // The 4->1 mux itself
  assign z_in = d[sel];

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] m_sample = 4'h0;
  logic [1:0] m_sel = 2'd0;
  logic [3:0] m_snap = 4'h0;
  logic [3:0] m_changed = 4'h0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_changed(input string tag);
`ifdef MUX4_SCAN_CHANGE_EN
    check(tag, changed, m_changed);
`endif
  endtask

  task automatic model_finish();
    m_changed = m_sample ^ m_snap;
    m_snap    = m_sample;
  endtask

  // Called at #1 after a posedge with the DUT idle; returns in the same phase.
  task automatic run_scan(input logic [3:0] mask, input logic [3:0] dv,
                          input int abort_at, input bit noise);
    logic [1:0] ch_list[$];
    int e, n;
    ch_list = {};
    for (int i = 0; i < 4; i++) if (mask[i]) ch_list.push_back(2'(i));
    e = ch_list.size();
    n = e * DWELL;
    exp_q = {};
    foreach (ch_list[k]) repeat (DWELL) exp_q.push_back(ch_list[k]);

    d = dv;
    ch_en = mask;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    for (int c = 1; c <= n; c++) begin
      check("scan_sel", sel, exp_q.pop_front());
      check("scan_busy", busy, 1);
      check("scan_done", done, 0);
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        ch_en = 4'($urandom);
      end
      if (c == abort_at) abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      if (c == abort_at) begin
        // Channel p (1-based) is captured on edge p*DWELL; the abort edge captures nothing.
        for (int p = 1; p <= e; p++)
          if (p * DWELL < c) m_sample[ch_list[p-1]] = dv[ch_list[p-1]];
        m_sel = ch_list[(c - 1) / DWELL];
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sel", sel, m_sel);
        check("abort_sample", sample, m_sample);
        check_changed("abort_changed");
        @(posedge clk); #1;
        check("abort_idle_busy", busy, 0);
        check("abort_idle_done", done, 0);
        return;
      end
    end

    // Cycle n+1: the done pulse
    m_sample = (m_sample & ~mask) | (dv & mask);
    if (e > 0) m_sel = ch_list[e-1];
    check("fin_done", done, 1);
    check("fin_busy", busy, 0);
    check("fin_sel", sel, m_sel);
    check("fin_sample", sample, m_sample);
    if (noise) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_finish();
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_sel", sel, m_sel);
    check("post_sample", sample, m_sample);
    check_changed("post_changed");
    @(posedge clk); #1;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sel"}, sel, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_sample"}, sample, 0);
    check_changed({tag, "_changed"});
  endtask

  initial begin
    logic [3:0] rmask, rd;
    int ab;

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Change-mask pair, then the canonical full scan
    run_scan(4'b1111, 4'b0011, 0, 1'b0);
    run_scan(4'b1111, 4'b0101, 0, 1'b0);
    run_scan(4'b1111, 4'b1010, 0, 1'b0);

    // Async reset between edges in the middle of a scan
    d = 4'($urandom);
    ch_en = 4'b1111;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    m_sample = '0; m_sel = '0; m_snap = '0; m_changed = '0;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midreset_nodone", done, 0);
    check("midreset_nobusy", busy, 0);

    // Sparse mask from a cleared sample, then an empty scan
    run_scan(4'b1001, 4'b1111, 0, 1'b0);
    check("sparse_result", sample, 4'b1001);
    run_scan(4'b0000, 4'b0110, 0, 1'b0);
    check("empty_result", sample, 4'b1001);

    // Abort during the second cycle of channel 2
    run_scan(4'b1111, 4'b0000, 0, 1'b0);
    run_scan(4'b1111, 4'b1111, 3 * DWELL, 1'b0);
    check("abort_result", sample, 4'b0011);
    run_scan(4'b1111, 4'b0110, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      rmask = 4'($urandom);
      rd = 4'($urandom);
      ab = 0;
      if (rmask != 0 && $urandom_range(0, 3) == 0)
        ab = $urandom_range(1, $countones(rmask) * DWELL);
      run_scan(rmask, rd, ab, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
